seg_capture: RTL and testbench

Receiving end of the multiplexed four-digit seven-segment interface driven by the team's display block. It watches the `scathod`/`ssegment` lines and rebuilds the 16-bit hex value being displayed. It publishes that value only after the same value has been seen for several consecutive complete scan frames. It sits in self-checking and loop-back builds, where it turns display output back into `digit` data for comparison.

---
 rtl/seg_capture.sv | 174 +++++++++++++++++
 tb/tb_seg_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// seg_capture
//   Receiving end of a multiplexed four-digit seven-segment display. It
//   watches the digit selects and segment lines, rebuilds the 16-bit hex
//   value being shown, and publishes that value once the same error-free
//   frame has been seen STABLE_FRAMES times in a row.
//
// Parameters
//   SETTLE        cycles a one-hot select must hold before sampling (2..65535)
//   STABLE_FRAMES identical clean frames needed before publishing (1..15)
//
// Ports
//   sys_clk   in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   scathod   in   4  digit selects, active-low, bit n -> digit[4n+3:4n]
//   ssegment  in   7  segments, active-low, bit 0 = a .. bit 6 = g
//   digit     out 16  last published value
//   valid     out  1  one-cycle pulse when digit is written
//   seg_err   out  1  one-cycle pulse on an undecodable sampled pattern
module seg_capture #(
  parameter int SETTLE        = 16,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [3:0]  scathod,
  input  logic [6:0]  ssegment,
  output logic [15:0] digit,
  output logic        valid,
  output logic        seg_err
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [3:0]  STABLE_CNT  = 4'(STABLE_FRAMES);

  logic [3:0]  sc_q;
  logic [3:0]  sc_prev;
  logic [6:0]  sg_q;
  logic [15:0] settle_cnt;

  logic [15:0] frame_buf;
  logic [3:0]  frame_mask;
  logic        frame_err;
  logic [15:0] cand;
  logic [3:0]  match_cnt;
  logic        published;

  logic        sel_onehot;
  logic [1:0]  sel_idx;
  logic        settle_clear;
  logic        sample;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic [15:0] buf_next;
  logic [3:0]  mask_next;
  logic        err_next;
  logic        complete;
  logic [3:0]  match_upd;
  logic [15:0] cand_upd;
  logic        publish;

  // Select qualification: blanking (all ones) and multi-digit selects are
  // simply not one-hot-low, so they hold the settle counter at zero.
  always_comb begin
    sel_onehot   = $onehot(~sc_q);
    sel_idx      = 2'd0;
    case (sc_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
    settle_clear = (sc_q != sc_prev) || !sel_onehot;
    // The counter keeps counting past SETTLE-1, so a long dwell samples once.
    sample       = !settle_clear && (settle_cnt == SETTLE_LAST);
  end

  // Segment decode of the active-high gfedcba pattern.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (~sg_q)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Frame assembly and the candidate/match bookkeeping for a completing
  // sample. An errored digit still marks its mask bit so the frame can
  // complete and be thrown away.
  always_comb begin
    buf_next = frame_buf;
    if (dec_ok) buf_next[{sel_idx, 2'b00} +: 4] = dec_nib;
    mask_next = frame_mask | (4'b0001 << sel_idx);
    err_next  = frame_err | !dec_ok;
    complete  = sample && (mask_next == 4'hF);

    match_upd = match_cnt;
    cand_upd  = cand;
    if (err_next) begin
      match_upd = 4'd0;
    end else if (buf_next == cand) begin
      match_upd = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
    end else begin
      cand_upd  = buf_next;
      match_upd = 4'd1;
    end

    publish = complete && !err_next && (match_upd == STABLE_CNT) &&
              ((cand_upd != digit) || !published);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sc_q       <= 4'h0;
      sc_prev    <= 4'h0;
      sg_q       <= 7'h00;
      settle_cnt <= 16'd0;
      frame_buf  <= 16'h0000;
      frame_mask <= 4'h0;
      frame_err  <= 1'b0;
      cand       <= 16'h0000;
      match_cnt  <= 4'd0;
      published  <= 1'b0;
      digit      <= 16'h0000;
      valid      <= 1'b0;
      seg_err    <= 1'b0;
    end else begin
      sc_q    <= scathod;
      sg_q    <= ssegment;
      sc_prev <= sc_q;

      if (settle_clear)             settle_cnt <= 16'd0;
      else if (settle_cnt != 16'hFFFF) settle_cnt <= settle_cnt + 16'd1;

      valid   <= publish;
      seg_err <= sample && !dec_ok;

      if (sample) begin
        if (complete) begin
          frame_buf  <= 16'h0000;
          frame_mask <= 4'h0;
          frame_err  <= 1'b0;
          match_cnt  <= match_upd;
          cand       <= cand_upd;
          if (publish) begin
            digit     <= cand_upd;
            published <= 1'b1;
          end
        end else begin
          frame_buf  <= buf_next;
          frame_mask <= mask_next;
          frame_err  <= err_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture
//   Directed bench for seg_capture. Frames are scanned digit 0..3; a small
//   frame-level model predicts each publication (value and cycle) and pushes
//   it to a scoreboard queue that a monitor pops on every valid pulse.
module tb_seg_capture;

  localparam int SETTLE        = 16;
  localparam int STABLE_FRAMES = 2;
  localparam int DWELL         = 32;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [15:0] value;
    int          cyc;
  } pub_t;

  logic        sys_clk;
  logic        rst;
  logic [3:0]  scathod;
  logic [6:0]  ssegment;
  logic [15:0] digit;
  logic        valid;
  logic        seg_err;

  int checks;
  int failures;
  int cyc;
  int seg_err_seen;
  int exp_seg_err;

  pub_t sb[$];

  logic [15:0] m_cand;
  int          m_match;
  bit          m_pub;
  logic [15:0] m_digit;

  seg_capture #(.SETTLE(SETTLE), .STABLE_FRAMES(STABLE_FRAMES)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .scathod  (scathod),
    .ssegment (ssegment),
    .digit    (digit),
    .valid    (valid),
    .seg_err  (seg_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Active-low segment pattern for a nibble.
  function automatic logic [6:0] segOf(input logic [3:0] nib);
    logic [6:0] p;
    p = SEG_TAB[nib];
    return ~p;
  endfunction

  function automatic logic [27:0] rawOf(input logic [15:0] v);
    logic [27:0] r;
    for (int d = 0; d < 4; d++) r[7*d +: 7] = segOf(v[4*d +: 4]);
    return r;
  endfunction

  function automatic bit decodeSeg(input logic [6:0] raw, output logic [3:0] nib);
    logic [6:0] hi;
    hi  = ~raw;
    nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hi === SEG_TAB[i]) begin
        nib = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, output int t);
    @(posedge sys_clk);
    #1;
    scathod  = sel;
    ssegment = seg;
    t        = cyc;
  endtask

  task automatic modelReset();
    m_cand  = 16'h0000;
    m_match = 0;
    m_pub   = 1'b0;
    m_digit = 16'h0000;
  endtask

  // Scan one full frame; raw holds active-low segment patterns per digit.
  task automatic scanFrame(input logic [27:0] raw, input bit glitch);
    logic [15:0] val;
    logic [3:0]  nib;
    bit          err;
    bit          pub;
    int          t;
    val = 16'h0000;
    err = 1'b0;
    pub = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (decodeSeg(raw[7*d +: 7], nib)) val[4*d +: 4] = nib;
      else begin
        err = 1'b1;
        exp_seg_err++;
      end
    end
    if (err) m_match = 0;
    else begin
      if (val == m_cand) m_match = (m_match == 15) ? 15 : m_match + 1;
      else begin
        m_cand  = val;
        m_match = 1;
      end
      pub = (m_match == STABLE_FRAMES) && ((m_cand != m_digit) || !m_pub);
    end
    for (int d = 0; d < 4; d++) begin
      if (glitch && d > 0) begin
        applyStimulus(~(4'b0001 << ((d + 1) % 4)), 7'h55, t);
        repeat (7) @(posedge sys_clk);
        applyStimulus(4'b0011, 7'h55, t);
        repeat (9) @(posedge sys_clk);
      end
      applyStimulus(~(4'b0001 << d), raw[7*d +: 7], t);
      if (d == 3 && pub) begin
        sb.push_back('{value: m_cand, cyc: t + SETTLE + 2});
        m_digit = m_cand;
        m_pub   = 1'b1;
      end
      repeat (DWELL - 1) @(posedge sys_clk);
    end
  endtask

  task automatic doReset();
    int t;
    applyStimulus(4'hF, 7'h7F, t);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    modelReset();
    @(negedge sys_clk);
    checkOutput("reset_digit", 32'(digit), 32'h0);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_seg_err", 32'(seg_err), 32'h0);
    repeat (4) @(posedge sys_clk);
  endtask

  // Monitor: every valid pops the scoreboard; valid and seg_err must not overlap.
  always @(negedge sys_clk) begin
    if (!rst && (valid || seg_err)) begin
      checkOutput("valid_seg_err_overlap", 32'(valid & seg_err), 32'h0);
      if (seg_err) seg_err_seen++;
      if (valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid_digit", 32'(digit), 32'hFFFF_FFFF);
        end else begin
          pub_t e;
          e = sb.pop_front();
          checkOutput("pub_value", 32'(digit), 32'(e.value));
          checkOutput("pub_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    logic [27:0] raw;
    int          t;
    checks       = 0;
    failures     = 0;
    seg_err_seen = 0;
    exp_seg_err  = 0;
    rst          = 1'b1;
    scathod      = 4'hF;
    ssegment     = 7'h7F;
    modelReset();
    repeat (3) @(posedge sys_clk);
    doReset();

    // Basic scan: publish after two frames, then hold without re-pulsing.
    for (int f = 0; f < 5; f++) scanFrame(rawOf(16'h1A2F), 1'b0);
    checkOutput("digit_1A2F", 32'(digit), 32'h1A2F);

    // Value changes mid-frame: the mixed frame must never publish.
    raw = rawOf(16'hBEEF);
    raw[13:0] = rawOf(16'h1A2F) >> 0;
    raw[13:0] = rawOf(16'h1A2F) & 28'h3FFF;
    scanFrame(raw, 1'b0);
    checkOutput("digit_after_mixed", 32'(digit), 32'h1A2F);
    for (int f = 0; f < 2; f++) scanFrame(rawOf(16'hBEEF), 1'b0);
    checkOutput("digit_BEEF", 32'(digit), 32'hBEEF);

    // Illegal pattern: seg_err once, frame discarded, match count restarts.
    scanFrame(rawOf(16'hC583), 1'b0);
    raw = rawOf(16'hC583);
    raw[13:7]  = 7'h00;
    raw[20:14] = 7'b1010101;
    scanFrame(raw, 1'b0);
    checkOutput("seg_err_count_err", 32'(seg_err_seen), 32'(exp_seg_err));
    scanFrame(rawOf(16'hC583), 1'b0);
    checkOutput("digit_no_early_pub", 32'(digit), 32'hBEEF);
    scanFrame(rawOf(16'hC583), 1'b0);
    checkOutput("digit_C583", 32'(digit), 32'hC583);

    // Select glitches and a two-digit-low period between digits.
    for (int f = 0; f < 3; f++) scanFrame(rawOf(16'h7E41), 1'b1);
    checkOutput("digit_7E41", 32'(digit), 32'h7E41);
    checkOutput("seg_err_count_glitch", 32'(seg_err_seen), 32'(exp_seg_err));

    // Zero value after reset still publishes once.
    doReset();
    for (int f = 0; f < 3; f++) scanFrame(rawOf(16'h0000), 1'b0);
    checkOutput("digit_zero", 32'(digit), 32'h0);

    // Reset after three digits of a frame discards the partial frame.
    raw = rawOf(16'h1A2F);
    for (int d = 0; d < 3; d++) begin
      applyStimulus(~(4'b0001 << d), raw[7*d +: 7], t);
      repeat (DWELL - 1) @(posedge sys_clk);
    end
    doReset();
    scanFrame(rawOf(16'h1A2F), 1'b0);
    checkOutput("digit_one_frame_after_reset", 32'(digit), 32'h0);
    scanFrame(rawOf(16'h1A2F), 1'b0);
    checkOutput("digit_two_frames_after_reset", 32'(digit), 32'h1A2F);

    repeat (40) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    checkOutput("seg_err_count_final", 32'(seg_err_seen), 32'(exp_seg_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
